// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered asynchronous serial transmitter with a configurable
// frame format (data width, parity, stop bits), bit period and buffer depth.
module uart_tx_fifo #(
   parameter int CLK_DIV    = 104,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 data_wr,
   output logic                 ack,
   output logic                 full,
   output logic                 tx,
   output logic                 busy,
   output logic                 end_of_send
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_nxt;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 push, pop;
   logic [DW-1:0]        div_cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 bit_done, frame_done, tx_nxt;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
      return (PARITY == 1) ? ~(^w) : (^w);
   endfunction

   assign full       = (count == (AW+1)'(FIFO_DEPTH));
   assign push       = data_wr && !full;
   assign bit_done   = (div_cnt == '0);
   assign frame_done = (state == STOP) && bit_done && (bit_idx == STOP_LAST);
   // The head is popped either from IDLE or on the final stop clock, so
   // back-to-back frames leave no idle gap on the line.
   assign pop        = (count != '0) && ((state == IDLE) || frame_done);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ack    <= 1'b0;
      end else begin
         ack <= push;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shreg   <= mem[rd_ptr];
         par_bit <= parity_of(mem[rd_ptr]);
      end else if (state == DATA && bit_done) begin
         shreg <= shreg >> 1;
      end
   end

   // Line outputs are registered from the current state, so tx, busy and
   // end_of_send all trail the FSM by one clock and stay mutually aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         div_cnt     <= DIV_LAST;
         bit_idx     <= '0;
         tx          <= 1'b1;
         busy        <= 1'b0;
         end_of_send <= 1'b0;
      end else begin
         state       <= state_nxt;
         tx          <= tx_nxt;
         busy        <= (state != IDLE);
         end_of_send <= frame_done;
         if (state == IDLE || bit_done) div_cnt <= DIV_LAST;
         else                           div_cnt <= div_cnt - DW'(1);
         if (state_nxt != state) bit_idx <= '0;
         else if (bit_done)      bit_idx <= bit_idx + 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      tx_nxt    = 1'b1;
      case (state)
         IDLE: begin
            if (pop) state_nxt = START;
         end
         START: begin
            tx_nxt = 1'b0;
            if (bit_done) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shreg[0];
            if (bit_done && bit_idx == DATA_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
         end
         PAR: begin
            tx_nxt = par_bit;
            if (bit_done) state_nxt = STOP;
         end
         STOP: begin
            if (frame_done) state_nxt = pop ? START : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats driven with directed and random writes,
// scored against a queue-and-time model of the buffer and the serial line.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
   localparam int NCFG    = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      din [NCFG];
   logic [NCFG-1:0] wr;
   logic [NCFG-1:0] ack, full, tx, busy, eos;
   int              n_cmp = 0;
   int              n_fail = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input int g, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cfg%0d t=%0t: got %0d, expected %0d", name, g, $time, act, exp);
      end
   endtask

   // cfg0: 8N1, cfg1: 8E1, cfg2: 8O1, cfg3: 7N2
   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int DB = (g == 3) ? 7 : 8;
      localparam int PB = (g == 1) ? 2 : (g == 2) ? 1 : 0;
      localparam int SB = (g == 3) ? 2 : 1;
      localparam int L  = CLK_DIV * (1 + DB + ((PB != 0) ? 1 : 0) + SB);
      localparam logic [7:0] MASK = 8'((1 << DB) - 1);

      uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(DB), .PARITY(PB),
                     .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
         .clk(clk), .rst(rst), .data_in(din[g][DB-1:0]), .data_wr(wr[g]),
         .ack(ack[g]), .full(full[g]), .tx(tx[g]), .busy(busy[g]),
         .end_of_send(eos[g]));

      // Line level of bit i of the frame carrying word w.
      function automatic int line_bit(input logic [7:0] w, input int i);
         int ones;
         ones = $countones(w);
         if (i == 0) return 0;
         if (i <= DB) return int'(w[i-1]);
         if (PB != 0 && i == DB + 1) return (PB == 2) ? (ones % 2) : (1 - (ones % 2));
         return 1;
      endfunction

      logic [7:0] sbq[$];
      int   mq_n = 0;
      int   e = 0;
      int   frame_end = -1;
      int   busy_from = 1;
      int   busy_to = 0;
      logic ack_exp = 1'b0;
      logic eos_exp = 1'b0;
      int   n_ack = 0;
      int   n_frames = 0;
      int   pre;
      logic acc;

      // Model: words waiting in the buffer, and the edge at which the current frame ends.
      always @(posedge clk) begin
         e++;
         if (rst) begin
            sbq.delete();
            mq_n = 0; frame_end = -1; busy_from = 1; busy_to = 0;
            ack_exp = 1'b0; eos_exp = 1'b0;
         end else begin
            pre = mq_n;
            acc = wr[g] && (pre < DEPTH);
            eos_exp = (e == frame_end);
            if (e >= frame_end && pre > 0) begin
               mq_n--;
               if (busy_to != e) busy_from = e + 1;
               busy_to = e + L;
               frame_end = e + L;
            end
            if (acc) begin
               mq_n++;
               sbq.push_back(din[g] & MASK);
            end
            ack_exp = acc;
         end
      end

      logic       in_frame = 1'b0;
      int         k = 0;
      logic [7:0] cur = '0;

      always @(negedge clk) begin
         check("ack", g, ack[g], ack_exp);
         check("full", g, full[g], mq_n == DEPTH);
         check("busy", g, busy[g], (e >= busy_from) && (e <= busy_to));
         check("end_of_send", g, eos[g], eos_exp);
         if (ack[g]) n_ack++;
         if (rst) begin
            in_frame = 1'b0;
         end else begin
            if (!in_frame && busy[g]) begin
               check("queued_word", g, sbq.size() > 0, 1);
               if (sbq.size() > 0) begin
                  cur = sbq.pop_front();
                  in_frame = 1'b1;
                  k = 0;
               end
            end
            if (in_frame) begin
               check("tx_bit", g, tx[g], line_bit(cur, k / CLK_DIV));
               k++;
               if (k == L) begin
                  in_frame = 1'b0;
                  n_frames++;
               end
            end else begin
               check("tx_idle", g, tx[g], 1);
            end
         end
      end
   end

   task automatic write_word(input int g, input logic [7:0] w);
      @(negedge clk);
      din[g] = w;
      wr[g]  = 1'b1;
      @(negedge clk);
      wr[g]  = 1'b0;
   endtask

   task automatic wait_frame(input int g, output int blen, output int eos_first,
                             output int eos_last, output logic [31:0] bits);
      int t;
      blen = 0; eos_first = 0; eos_last = 0; bits = '1; t = 0;
      while (!busy[g] && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("frame_started", g, busy[g], 1);
      while (busy[g] && blen < 400) begin
         blen++;
         if ((blen - 1) % CLK_DIV == 1 && (blen - 1) / CLK_DIV < 32)
            bits[(blen - 1) / CLK_DIV] = tx[g];
         if (eos[g]) begin
            if (eos_first == 0) eos_first = blen;
            eos_last = blen;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int quiet, t;
      quiet = 0; t = 0;
      while (quiet < 3 && t < 3000) begin
         @(negedge clk);
         t++;
         if (busy == '0 && cfg[0].mq_n == 0 && cfg[1].mq_n == 0 &&
             cfg[2].mq_n == 0 && cfg[3].mq_n == 0) quiet++;
         else quiet = 0;
      end
      check("drained", 0, quiet, 3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int blen, ef, el, acks0, frames0, seen;
      logic [31:0] bits;

      for (int g = 0; g < NCFG; g++) din[g] = '0;
      wr  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", 0, tx[0], 1);
      check("rst_busy", 0, busy[0], 0);
      check("rst_ack", 0, ack[0], 0);
      check("rst_full", 0, full[0], 0);
      check("rst_eos", 0, eos[0], 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 0xA5 on 8N1, with first-bit latency
      write_word(0, 8'hA5);
      check("lat_ack_n1", 0, ack[0], 1);
      check("lat_tx_n1", 0, tx[0], 1);
      @(negedge clk);
      check("lat_ack_n2", 0, ack[0], 0);
      check("lat_tx_n2", 0, tx[0], 1);
      @(negedge clk);
      check("lat_tx_n3", 0, tx[0], 0);
      check("lat_busy_n3", 0, busy[0], 1);
      wait_frame(0, blen, ef, el, bits);
      check("a5_len", 0, blen, 40);
      check("a5_eos", 0, ef, 40);
      check("a5_bits", 0, int'(bits[9:0]), int'(10'b1101001010));
      wait_idle();

      // Parity: even then odd on 0x03
      write_word(1, 8'h03);
      wait_frame(1, blen, ef, el, bits);
      check("even_len", 1, blen, 44);
      check("even_par", 1, bits[9], 0);
      check("even_stop", 1, bits[10], 1);
      write_word(2, 8'h03);
      wait_frame(2, blen, ef, el, bits);
      check("odd_len", 2, blen, 44);
      check("odd_par", 2, bits[9], 1);

      // 7 data bits, 2 stop bits
      write_word(3, 8'h7F);
      wait_frame(3, blen, ef, el, bits);
      check("7n2_len", 3, blen, 40);
      check("7n2_stop", 3, int'(bits[9:8]), 3);
      check("7n2_eos", 3, ef, 40);
      wait_idle();

      // Six writes on consecutive cycles: five fit (one popped, four buffered), sixth dropped
      acks0 = cfg[0].n_ack;
      frames0 = cfg[0].n_frames;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) check("full_burst", 0, full[0], 1);
         din[0] = 8'($urandom);
         wr[0]  = 1'b1;
      end
      @(negedge clk);
      wr[0] = 1'b0;
      check("ack_dropped", 0, ack[0], 0);
      wait_idle();
      check("acks_eq_frames", 0, cfg[0].n_ack - acks0, cfg[0].n_frames - frames0);
      check("burst_frames", 0, cfg[0].n_frames - frames0, 5);

      // Two queued words go out back to back
      @(negedge clk);
      din[0] = 8'h01; wr[0] = 1'b1;
      @(negedge clk);
      din[0] = 8'h80;
      @(negedge clk);
      wr[0] = 1'b0;
      wait_frame(0, blen, ef, el, bits);
      check("b2b_len", 0, blen, 80);
      check("b2b_eos1", 0, ef, 40);
      check("b2b_eos2", 0, el, 80);
      wait_idle();

      // Random traffic, alternating sparse and dense phases
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int g = 0; g < NCFG; g++) begin
            wr[g]  = ($urandom_range(0, ((c / 300) % 2 == 1) ? 1 : 7) == 0);
            din[g] = 8'($urandom);
         end
      end
      @(negedge clk);
      wr = '0;
      wait_idle();
      check("sb_empty", 0, cfg[0].sbq.size(), 0);
      check("sb_empty", 1, cfg[1].sbq.size(), 0);
      check("sb_empty", 2, cfg[2].sbq.size(), 0);
      check("sb_empty", 3, cfg[3].sbq.size(), 0);

      // Reset in the middle of a data bit with more words queued
      frames0 = cfg[0].n_frames;
      @(negedge clk);
      din[0] = 8'h00; wr[0] = 1'b1;
      @(negedge clk);
      din[0] = 8'h5A;
      @(negedge clk);
      din[0] = 8'h33;
      @(negedge clk);
      wr[0] = 1'b0;
      seen = 0;
      while (!busy[0] && seen < 50) begin
         @(negedge clk);
         seen++;
      end
      repeat (10) @(negedge clk);
      check("pre_rst_tx", 0, tx[0], 0);
      #1 rst = 1'b1;
      #1;
      check("async_tx", 0, tx[0], 1);
      check("async_busy", 0, busy[0], 0);
      check("async_full", 0, full[0], 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (busy[0]) seen++;
      end
      check("post_rst_busy", 0, seen, 0);
      check("post_rst_frames", 0, cfg[0].n_frames - frames0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
